// File: rtl/can_pkg.sv
// Shared types and default timing for the CAN bit timing logic.
// Defaults give 20 tq per bit at 5 clk per tq (500 kbit/s from 50 MHz).
package can_pkg;

    typedef enum logic [1:0] {SEG_SYNC, SEG_TSEG1, SEG_TSEG2} seg_t;

    localparam int DEF_BRP   = 5;
    localparam int DEF_TSEG1 = 15;
    localparam int DEF_TSEG2 = 4;
    localparam int DEF_SJW   = 1;

    // Quantum counter covers the longest segment (16 + 4 lengthen).
    localparam int QCNT_W = 5;
    // Jump amounts hold 0..4.
    localparam int JUMP_W = 3;

endpackage

// File: rtl/can_tq_prescaler.sv
// Divides clk into time quanta; tq_tick marks the last clk of each quantum.
// restart realigns the quantum boundary for a hard resynchronisation.
module can_tq_prescaler #(
    parameter int BRP = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tq_tick
);

    localparam int PW = $clog2(BRP + 1);

    logic [PW-1:0] cnt;

    assign tq_tick = (cnt == PW'(BRP - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (restart || tq_tick)
            cnt <= '0;
        else
            cnt <= cnt + PW'(1);
    end

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit timing: sequences SYNC/TSEG1/TSEG2 per bit, emits tx and sample
// points, and resynchronises on recessive-to-dominant edges.
module can_bit_timing
    import can_pkg::*;
#(
    parameter int BRP   = DEF_BRP,
    parameter int TSEG1 = DEF_TSEG1,
    parameter int TSEG2 = DEF_TSEG2,
    parameter int SJW   = DEF_SJW
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_sync_edge,
    output logic sample_point,
    output logic tx_point
);

    seg_t              seg;
    logic [QCNT_W-1:0] qcnt;
    logic [JUMP_W-1:0] lengthen;
    logic [JUMP_W-1:0] shorten;
    logic              resync_done;
    logic              restart_pend;
    logic              tq_tick;

    // restart_pend comes out of reset set, so the first clk after release
    // starts SYNC exactly like a hard resync does.
    can_tq_prescaler #(.BRP(BRP)) u_presc (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_pend),
        .tq_tick (tq_tick)
    );

    logic              resync;
    logic              hard_sync;
    logic [QCNT_W-1:0] elapsed;
    logic [QCNT_W-1:0] remain;
    logic [JUMP_W-1:0] len_nxt;
    logic [JUMP_W-1:0] shr_nxt;
    logic [QCNT_W-1:0] tseg1_last;
    logic [QCNT_W-1:0] tseg2_last;

    assign resync  = rx_sync_edge && !resync_done && !restart_pend;
    assign elapsed = qcnt + QCNT_W'(1);
    assign remain  = QCNT_W'(TSEG2) - qcnt;

    always_comb begin
        len_nxt   = lengthen;
        shr_nxt   = shorten;
        hard_sync = 1'b0;
        if (resync) begin
            case (seg)
                SEG_TSEG1: len_nxt = (elapsed < QCNT_W'(SJW)) ? JUMP_W'(elapsed) : JUMP_W'(SJW);
                SEG_TSEG2: begin
                    if (remain <= QCNT_W'(SJW))
                        hard_sync = 1'b1;
                    else
                        shr_nxt = JUMP_W'(SJW);
                end
                default: ;
            endcase
        end
    end

    // Segment ends use this edge's jump so a shorten landing on the final tick applies now.
    assign tseg1_last = QCNT_W'(TSEG1 - 1) + QCNT_W'(len_nxt);
    assign tseg2_last = QCNT_W'(TSEG2 - 1) - QCNT_W'(shr_nxt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg          <= SEG_SYNC;
            qcnt         <= '0;
            lengthen     <= '0;
            shorten      <= '0;
            resync_done  <= 1'b0;
            restart_pend <= 1'b1;
            sample_point <= 1'b0;
            tx_point     <= 1'b0;
        end else begin
            sample_point <= 1'b0;
            tx_point     <= 1'b0;
            if (restart_pend) begin
                restart_pend <= 1'b0;
                seg          <= SEG_SYNC;
                qcnt         <= '0;
                lengthen     <= '0;
                shorten      <= '0;
                resync_done  <= 1'b0;
                tx_point     <= 1'b1;
            end else if (hard_sync) begin
                // Hold the FSM this cycle so SYNC starts only once, on the next edge.
                restart_pend <= 1'b1;
                resync_done  <= 1'b1;
            end else begin
                if (resync)
                    resync_done <= 1'b1;
                lengthen <= len_nxt;
                shorten  <= shr_nxt;
                if (tq_tick) begin
                    qcnt <= qcnt + QCNT_W'(1);
                    case (seg)
                        SEG_SYNC: begin
                            seg  <= SEG_TSEG1;
                            qcnt <= '0;
                        end
                        SEG_TSEG1: if (qcnt == tseg1_last) begin
                            seg          <= SEG_TSEG2;
                            qcnt         <= '0;
                            sample_point <= 1'b1;
                        end
                        SEG_TSEG2: if (qcnt == tseg2_last) begin
                            seg         <= SEG_SYNC;
                            qcnt        <= '0;
                            tx_point    <= 1'b1;
                            lengthen    <= '0;
                            shorten     <= '0;
                            resync_done <= 1'b0;
                        end
                        default: seg <= SEG_SYNC;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_can_bit_timing.sv
// Bench for can_bit_timing: directed vector table, randomized edges against
// an arithmetic bit-timing model, and reset corner sequences.
module tb_can_bit_timing;

    localparam int BRP = 5;
    localparam int T1  = 15;
    localparam int T2  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_a = 1'b0;
    logic rx_b = 1'b0;
    logic tx_a, sp_a, tx_b, sp_b;

    int total = 0;
    int bad   = 0;

    can_bit_timing dut_a (
        .clk          (clk),
        .rst          (rst),
        .rx_sync_edge (rx_a),
        .sample_point (sp_a),
        .tx_point     (tx_a)
    );

    can_bit_timing #(.BRP(BRP), .TSEG1(T1), .TSEG2(T2), .SJW(4)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .rx_sync_edge (rx_b),
        .sample_point (sp_b),
        .tx_point     (tx_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    sel;
        int    d1;
        int    d2;
        int    sp;
        int    len;
        string nm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
        end
    endtask

    // Offsets are in clk from the tx_point edge; an edge at offset d sees the
    // bit position d-1 clk in. Only the first edge of a bit matters.
    function automatic void model(input int d1, input int sjw, output int sp, output int len);
        int q, e, j;
        sp  = BRP * (1 + T1);
        len = BRP * (1 + T1 + T2);
        if (d1 > 0) begin
            q = (d1 - 1) / BRP;
            if (q >= 1 && q <= T1) begin
                j   = (q < sjw) ? q : sjw;
                sp  += BRP * j;
                len += BRP * j;
            end else if (q > T1) begin
                e = T2 - (q - 1 - T1);
                if (e <= sjw) len = d1 + 1;
                else          len -= BRP * sjw;
            end
        end
    endfunction

    // Entered at the negedge following a tx_point edge; returns at the
    // negedge following the next expected tx_point.
    task automatic run_bit(input int sel, input int d1, input int d2,
                           input int sp_off, input int len, input string nm);
        logic tx, sp;
        for (int off = 0; off < len; off++) begin
            if (sel == 0) rx_a = (off + 1 == d1) || (off + 1 == d2);
            else          rx_b = (off + 1 == d1) || (off + 1 == d2);
            @(negedge clk);
            rx_a = 1'b0;
            rx_b = 1'b0;
            tx = (sel == 0) ? tx_a : tx_b;
            sp = (sel == 0) ? sp_a : sp_b;
            if (tx || off + 1 == len)    check({nm, "_tx"}, tx, off + 1 == len);
            if (sp || off + 1 == sp_off) check({nm, "_sp"}, sp, off + 1 == sp_off);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_a", tx_a, 1'b0);
        check("reset_sp_a", sp_a, 1'b0);
        check("reset_tx_b", tx_b, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("first_tx_a", tx_a, 1'b1);
        check("first_sp_a", sp_a, 1'b0);
        check("first_tx_b", tx_b, 1'b1);
    endtask

    initial begin
        int sp, len, d1, d2;

        vecs.push_back('{0,  0,  0, 80, 100, "nominal"});
        vecs.push_back('{0, 30,  0, 85, 105, "tseg1_edge"});
        vecs.push_back('{0,  0,  0, 80, 100, "recover"});
        vecs.push_back('{0, 85,  0, 80,  95, "tseg2_shorten"});
        vecs.push_back('{0, 30, 40, 85, 105, "double_edge"});
        vecs.push_back('{0,  2, 50, 80, 100, "sync_edge"});
        vecs.push_back('{0,  6,  0, 85, 105, "tseg1_first_tq"});
        vecs.push_back('{0, 81,  0, 80,  95, "tseg2_first_tq"});
        vecs.push_back('{0, 96,  0, 80,  97, "tseg2_last_hard"});
        vecs.push_back('{0,100,  0, 80, 101, "tseg2_tick_hard"});
        vecs.push_back('{0,  0,  0, 80, 100, "nominal_end"});
        vecs.push_back('{1, 95,  0, 80,  96, "sjw4_hard"});
        vecs.push_back('{1, 30,  0,100, 120, "sjw4_tseg1"});
        vecs.push_back('{1, 11,  0, 90, 110, "sjw4_tseg1_e2"});
        vecs.push_back('{1, 85,  0, 80,  86, "sjw4_tseg2_e4"});
        vecs.push_back('{1,  0,  0, 80, 100, "sjw4_nominal"});

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].sel != vecs[i-1].sel) do_reset();
            run_bit(vecs[i].sel, vecs[i].d1, vecs[i].d2, vecs[i].sp, vecs[i].len, vecs[i].nm);
        end

        for (int s = 0; s < 2; s++) begin
            do_reset();
            for (int b = 0; b < 250; b++) begin
                d1 = ($urandom_range(2) == 0) ? 0 : int'($urandom_range(100, 1));
                model(d1, (s == 0) ? 1 : 4, sp, len);
                d2 = 0;
                if (d1 > 0 && d1 + 1 <= len - 1 && $urandom_range(1) == 1)
                    d2 = int'($urandom_range(len - 1, d1 + 1));
                run_bit(s, d1, d2, sp, len, (s == 0) ? "rand_sjw1" : "rand_sjw4");
            end
        end

        // Reset mid-TSEG1, then timing restarts as after power-up.
        do_reset();
        run_bit(0, 0, 0, 80, 100, "pre_reset");
        repeat (30) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_reset_tx", tx_a, 1'b0);
        check("mid_reset_sp", sp_a, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("restart_tx", tx_a, 1'b1);
        run_bit(0, 0, 0, 80, 100, "after_reset");
        run_bit(0, 0, 0, 80, 100, "after_reset2");

        // Reset while a tx_point pulse is high clears it without a clock.
        rst = 1'b0;
        #1;
        check("async_clear_tx", tx_a, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("restart2_tx", tx_a, 1'b1);
        run_bit(0, 30, 0, 85, 105, "after_reset3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
